reg_file_mp: RTL and testbench

Multi-ported, parametrised integer register file for the RISC-V core. It is the successor of the single-write, dual-read register file.
- N_RD read ports and N_WR write ports.
- Per-register pending (scoreboard) bits, set at issue and cleared at writeback.
- Flush of all pending bits.
- Registered write-conflict flag.
- Sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_wr_arbiter.sv | 66 ++++++
 rtl/reg_file_mp.sv | 158 +++++++++++++++
 tb/tb_reg_file_mp.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multi-ported integer register file.
//   RF_NBW_ADDR  : default register address width (depth = 2**RF_NBW_ADDR)
//   RF_NBW_DATA  : default register data width
//   rf_addr_t    : register address type at the default width
//   rf_data_t    : register data type at the default width
//   RF_ZERO_ADDR : address of the hard-wired zero register x0
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_NBW_ADDR = 5;
    localparam int RF_NBW_DATA = 32;

    typedef logic [RF_NBW_ADDR-1:0] rf_addr_t;
    typedef logic [RF_NBW_DATA-1:0] rf_data_t;

    localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter
// Resolves the write ports of the register file per destination register.
// For every register it produces a one-hot vector naming the single write
// port that owns the register this cycle (highest-index enabled port wins),
// a per-register "written" flag, and a flag raised when two or more enabled
// ports target the same nonzero register. Writes to x0 are ignored entirely.
// The same winner vectors drive both the storage update and the optional
// write-to-read forwarding path in the top level.
//
// Ports:
//   wr_en     in   N_WR             write enable per port
//   wr_addr   in   N_WR*NBW_ADDR    write addresses, port p at [p*NBW_ADDR +: NBW_ADDR]
//   win       out  DEPTH*N_WR       one-hot winner, register r at [r*N_WR +: N_WR]
//   hit       out  DEPTH            register r is written this cycle
//   collision out  1                two or more enabled ports share a nonzero address
// -----------------------------------------------------------------------------
module rf_wr_arbiter
    import rf_pkg::*;
#(
    parameter  int NBW_ADDR = RF_NBW_ADDR,
    parameter  int N_WR     = 2,
    localparam int DEPTH    = 2**NBW_ADDR
) (
    input  logic [N_WR-1:0]          wr_en,
    input  logic [N_WR*NBW_ADDR-1:0] wr_addr,
    output logic [DEPTH*N_WR-1:0]    win,
    output logic [DEPTH-1:0]         hit,
    output logic                     collision
);

    localparam logic [NBW_ADDR-1:0] ZERO_ADDR = NBW_ADDR'(RF_ZERO_ADDR);

    logic [NBW_ADDR-1:0] addr_p;
    logic [NBW_ADDR-1:0] addr_q;

    always_comb begin
        win       = '0;
        hit       = '0;
        collision = 1'b0;
        addr_p    = '0;
        addr_q    = '0;

        // Ascending scan: a later (higher-index) port overwrites the claim of
        // an earlier port on the same register, so the highest index wins.
        for (int p = 0; p < N_WR; p++) begin
            addr_p = wr_addr[p*NBW_ADDR +: NBW_ADDR];
            if (wr_en[p] && (addr_p != ZERO_ADDR)) begin
                win[int'(addr_p)*N_WR +: N_WR]  = '0;
                win[int'(addr_p)*N_WR + p]      = 1'b1;
                hit[addr_p]                     = 1'b1;
            end
        end

        for (int p = 0; p < N_WR; p++) begin
            for (int q = p + 1; q < N_WR; q++) begin
                addr_p = wr_addr[p*NBW_ADDR +: NBW_ADDR];
                addr_q = wr_addr[q*NBW_ADDR +: NBW_ADDR];
                if (wr_en[p] && wr_en[q] && (addr_p == addr_q) && (addr_p != ZERO_ADDR)) begin
                    collision = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Multi-ported integer register file with per-register pending (scoreboard)
// bits. Sits between decode/issue (reads, reservations) and writeback (writes).
// x0 always reads 0, is never busy, and ignores writes and reservations.
//
// Optional build macro: RF_BYPASS_EN
//   defined   : same-cycle write-to-read forwarding of data, and busy reads 0
//               for a register being written unless it is also being reserved.
//   undefined : reads see stored data and stored pending bits only.
//
// Ports:
//   clk           in   1               rising-edge clock
//   rst_async_n   in   1               asynchronous active-low reset
//   i_rd_addr     in   N_RD*NBW_ADDR   read addresses, port k at [k*NBW_ADDR +: NBW_ADDR]
//   o_rd_dt       out  N_RD*NBW_DATA   read data (combinational), packed like i_rd_addr
//   o_rd_busy     out  N_RD            pending bit of each read port's register
//   i_wr_en       in   N_WR            write enable per port
//   i_wr_addr     in   N_WR*NBW_ADDR   write addresses, packed
//   i_wr_dt       in   N_WR*NBW_DATA   write data, packed
//   i_rsv_en      in   1               reserve (mark pending) request
//   i_rsv_addr    in   NBW_ADDR        register to reserve
//   i_flush       in   1               clear all pending bits
//   o_busy_vec    out  2**NBW_ADDR     registered pending-bit vector
//   o_wr_conflict out  1               registered same-address write collision pulse
// -----------------------------------------------------------------------------
module reg_file_mp
    import rf_pkg::*;
#(
    parameter  int NBW_ADDR = RF_NBW_ADDR,
    parameter  int NBW_DATA = RF_NBW_DATA,
    parameter  int N_RD     = 2,
    parameter  int N_WR     = 2,
    localparam int DEPTH    = 2**NBW_ADDR
) (
    input  logic                     clk,
    input  logic                     rst_async_n,
    input  logic [N_RD*NBW_ADDR-1:0] i_rd_addr,
    output logic [N_RD*NBW_DATA-1:0] o_rd_dt,
    output logic [N_RD-1:0]          o_rd_busy,
    input  logic [N_WR-1:0]          i_wr_en,
    input  logic [N_WR*NBW_ADDR-1:0] i_wr_addr,
    input  logic [N_WR*NBW_DATA-1:0] i_wr_dt,
    input  logic                     i_rsv_en,
    input  logic [NBW_ADDR-1:0]      i_rsv_addr,
    input  logic                     i_flush,
    output logic [DEPTH-1:0]         o_busy_vec,
    output logic                     o_wr_conflict
);

    localparam logic [NBW_ADDR-1:0] ZERO_ADDR = NBW_ADDR'(RF_ZERO_ADDR);

    logic [NBW_DATA-1:0]   mem [DEPTH];
    logic [NBW_DATA-1:0]   wr_dt_sel [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [DEPTH-1:0]      pend_nxt;
    logic [DEPTH-1:0]      rsv_vec;
    logic [DEPTH*N_WR-1:0] win;
    logic [DEPTH-1:0]      hit;
    logic                  collision;
    logic                  wr_conflict_q;
    logic [NBW_ADDR-1:0]   rd_a;
    logic [NBW_DATA-1:0]   rd_v;

    rf_wr_arbiter #(
        .NBW_ADDR (NBW_ADDR),
        .N_WR     (N_WR)
    ) u_wr_arbiter (
        .wr_en     (i_wr_en),
        .wr_addr   (i_wr_addr),
        .win       (win),
        .hit       (hit),
        .collision (collision)
    );

    // Data chosen for each register from its one-hot winning write port.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            wr_dt_sel[r] = '0;
            for (int p = 0; p < N_WR; p++) begin
                if (win[r*N_WR + p]) begin
                    wr_dt_sel[r] = i_wr_dt[p*NBW_DATA +: NBW_DATA];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (hit[r]) begin
                    mem[r] <= wr_dt_sel[r];
                end
            end
        end
    end

    always_comb begin
        rsv_vec = '0;
        if (i_rsv_en && (i_rsv_addr != ZERO_ADDR)) begin
            rsv_vec[i_rsv_addr] = 1'b1;
        end
    end

    // Applied lowest priority first so later assignments win:
    // hold < write-clear < reservation < flush. Reset is in the register.
    // A reservation beats a same-cycle write because it names a newer producer.
    always_comb begin
        pend_nxt = pend & ~hit;
        pend_nxt = pend_nxt | rsv_vec;
        if (i_flush) begin
            pend_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            pend          <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            pend          <= pend_nxt;
            wr_conflict_q <= collision;
        end
    end

    assign o_busy_vec    = pend;
    assign o_wr_conflict = wr_conflict_q;

    always_comb begin
        o_rd_dt   = '0;
        o_rd_busy = '0;
        rd_a      = '0;
        rd_v      = '0;
        for (int k = 0; k < N_RD; k++) begin
            rd_a = i_rd_addr[k*NBW_ADDR +: NBW_ADDR];
            rd_v = (rd_a == ZERO_ADDR) ? '0 : mem[rd_a];
            o_rd_busy[k] = pend[rd_a];
`ifdef RF_BYPASS_EN
            // hit[] is never set for x0, so x0 is never forwarded.
            if (hit[rd_a]) begin
                rd_v = '0;
                for (int p = 0; p < N_WR; p++) begin
                    if (win[int'(rd_a)*N_WR + p]) begin
                        rd_v = i_wr_dt[p*NBW_DATA +: NBW_DATA];
                    end
                end
                o_rd_busy[k] = rsv_vec[rd_a];
            end
`endif
            o_rd_dt[k*NBW_DATA +: NBW_DATA] = rd_v;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
// Self-checking bench for reg_file_mp (default parameters). A behavioural
// model (array of register values, pending vector, conflict flag) is advanced
// once per rising edge from the architectural rules; combinational reads are
// predicted from the model plus the inputs currently applied. Honours
// RF_BYPASS_EN when the bench is built with the same macro as the RTL.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file_mp;

    localparam int NA   = 5;
    localparam int ND   = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int DEP  = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_async_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic [NA-1:0]  rd_a [NRD];
    logic [NWR-1:0] we;
    logic [NA-1:0]  wa   [NWR];
    logic [ND-1:0]  wd   [NWR];
    logic           rsv_en;
    logic [NA-1:0]  rsv_addr;
    logic           flush;

    logic [NRD*NA-1:0] i_rd_addr;
    logic [NRD*ND-1:0] o_rd_dt;
    logic [NRD-1:0]    o_rd_busy;
    logic [NWR*NA-1:0] i_wr_addr;
    logic [NWR*ND-1:0] i_wr_dt;
    logic [DEP-1:0]    o_busy_vec;
    logic              o_wr_conflict;

    assign i_rd_addr = {rd_a[1], rd_a[0]};
    assign i_wr_addr = {wa[1], wa[0]};
    assign i_wr_dt   = {wd[1], wd[0]};

    reg_file_mp dut (
        .clk           (clk),
        .rst_async_n   (rst_async_n),
        .i_rd_addr     (i_rd_addr),
        .o_rd_dt       (o_rd_dt),
        .o_rd_busy     (o_rd_busy),
        .i_wr_en       (we),
        .i_wr_addr     (i_wr_addr),
        .i_wr_dt       (i_wr_dt),
        .i_rsv_en      (rsv_en),
        .i_rsv_addr    (rsv_addr),
        .i_flush       (flush),
        .o_busy_vec    (o_busy_vec),
        .o_wr_conflict (o_wr_conflict)
    );

    // ---------------- reference model ----------------
    logic [ND-1:0]  ref_mem [DEP];
    logic [DEP-1:0] ref_pend;
    logic           ref_conf;
    logic [ND-1:0]  exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void model_reset();
        for (int r = 0; r < DEP; r++) ref_mem[r] = '0;
        ref_pend = '0;
        ref_conf = 1'b0;
    endfunction

    // Architectural state update for one rising edge with the current inputs.
    function automatic void model_update();
        logic [DEP-1:0] np;
        int cnt [DEP];
        for (int r = 0; r < DEP; r++) cnt[r] = 0;
        np = ref_pend;
        for (int p = 0; p < NWR; p++) begin
            if (we[p] && wa[p] != 0) begin
                ref_mem[wa[p]] = wd[p];     // later port overwrites earlier
                np[wa[p]] = 1'b0;
                cnt[wa[p]]++;
            end
        end
        if (rsv_en && rsv_addr != 0) np[rsv_addr] = 1'b1;
        if (flush) np = '0;
        ref_pend = np;
        ref_conf = 1'b0;
        for (int r = 1; r < DEP; r++) if (cnt[r] > 1) ref_conf = 1'b1;
    endfunction

    function automatic logic [ND-1:0] exp_rd_dt(int k);
        logic [NA-1:0] a;
        logic [ND-1:0] v;
        a = rd_a[k];
        if (a == 0) return '0;
        v = ref_mem[a];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++) if (we[p] && wa[p] == a) v = wd[p];
`endif
        return v;
    endfunction

    function automatic logic exp_rd_busy(int k);
        logic [NA-1:0] a;
        logic b;
        a = rd_a[k];
        if (a == 0) return 1'b0;
        b = ref_pend[a];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p] == a) b = (rsv_en && rsv_addr == a);
`endif
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        we = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wr(int p, logic [NA-1:0] a, logic [ND-1:0] d);
        we[p] = 1'b1; wa[p] = a; wd[p] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rd_a[0] = '0; rd_a[1] = '0;
        rst_async_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_async_n = 1'b1;
        #1;
        for (int a = 0; a < DEP; a++) begin
            rd_a[0] = NA'(a);
            rd_a[1] = NA'(DEP - 1 - a);
            #1;
            for (int k = 0; k < NRD; k++) begin
                n_tests++;
                if (o_rd_dt[k*ND +: ND] !== '0 || o_rd_busy[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_read port%0d addr%0d: dt=%h busy=%b, want 0/0",
                             k, rd_a[k], o_rd_dt[k*ND +: ND], o_rd_busy[k]);
                end
            end
        end
        n_tests++;
        if (o_busy_vec !== '0 || o_wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vec: busy_vec=%h conflict=%b, want 0/0", o_busy_vec, o_wr_conflict);
        end
    endtask

    task automatic test_write_read();
        idle();
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        rd_a[1] = 5'd5;
        #1;
        n_tests++;
        if (o_rd_dt[ND +: ND] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read addr5: got %h want deadbeef", o_rd_dt[ND +: ND]);
        end
        wr(0, 5'd0, 32'h1234);
        tick();
        idle();
        rd_a[0] = 5'd0;
        #1;
        n_tests++;
        if (o_rd_dt[0 +: ND] !== 32'h0 || o_rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL write_x0: got dt=%h busy=%b want 0/0", o_rd_dt[0 +: ND], o_rd_busy[0]);
        end
    endtask

    task automatic test_conflict();
        idle();
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        tick();
        idle();
        rd_a[0] = 5'd7;
        #1;
        n_tests++;
        if (o_wr_conflict !== 1'b1 || o_rd_dt[0 +: ND] !== 32'h22) begin
            n_fail++;
            $display("FAIL conflict_addr7: conflict=%b dt=%h want 1/00000022", o_wr_conflict, o_rd_dt[0 +: ND]);
        end
        tick();
        n_tests++;
        if (o_wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_pulse: conflict=%b want 0 on second cycle", o_wr_conflict);
        end
        wr(0, 5'd0, 32'h33);
        wr(1, 5'd0, 32'h44);
        tick();
        idle();
        n_tests++;
        if (o_wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_x0: conflict=%b want 0", o_wr_conflict);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_a[0] = 5'd9;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        n_tests++;
        if (o_busy_vec[9] !== 1'b1 || o_rd_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv9: busy_vec[9]=%b rd_busy=%b want 1/1", o_busy_vec[9], o_rd_busy[0]);
        end
        wr(1, 5'd9, 32'h99);
        tick();
        idle();
        n_tests++;
        if (o_busy_vec[9] !== 1'b0) begin
            n_fail++;
            $display("FAIL write_clears9: busy_vec[9]=%b want 0", o_busy_vec[9]);
        end
        wr(0, 5'd9, 32'h9A);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        n_tests++;
        if (o_busy_vec[9] !== 1'b1 || o_rd_dt[0 +: ND] !== 32'h9A) begin
            n_fail++;
            $display("FAIL rsv_write9: busy=%b dt=%h want 1/0000009a", o_busy_vec[9], o_rd_dt[0 +: ND]);
        end
        rsv_en = 1'b1; rsv_addr = 5'd3; flush = 1'b1;
        tick();
        idle();
        n_tests++;
        if (o_busy_vec !== '0) begin
            n_fail++;
            $display("FAIL flush_rsv3: busy_vec=%h want 0", o_busy_vec);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr(0, 5'd12, 32'h0BADF00D);
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd12;
        tick();
        idle();
        rd_a[0] = 5'd12;
        wr(1, 5'd12, 32'hA5A5A5A5);
        #1;
        n_tests++;
`ifdef RF_BYPASS_EN
        if (o_rd_dt[0 +: ND] !== 32'hA5A5A5A5 || o_rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: dt=%h busy=%b want a5a5a5a5/0", o_rd_dt[0 +: ND], o_rd_busy[0]);
        end
`else
        if (o_rd_dt[0 +: ND] !== 32'h0BADF00D || o_rd_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL nobypass_same_cycle: dt=%h busy=%b want 0badf00d/1", o_rd_dt[0 +: ND], o_rd_busy[0]);
        end
`endif
        tick();
        idle();
        #1;
        n_tests++;
        if (o_rd_dt[0 +: ND] !== 32'hA5A5A5A5 || o_rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: dt=%h busy=%b want a5a5a5a5/0", o_rd_dt[0 +: ND], o_rd_busy[0]);
        end
    endtask

    task automatic test_random();
        logic [ND-1:0] e;
        idle();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NRD; k++) rd_a[k] = NA'($urandom_range(0, DEP - 1));
            for (int p = 0; p < NWR; p++) begin
                we[p] = ($urandom_range(0, 99) < 60);
                // narrow address window now and then to force collisions
                wa[p] = ($urandom_range(0, 3) == 0) ? NA'($urandom_range(0, 3))
                                                    : NA'($urandom_range(0, DEP - 1));
                wd[p] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) rd_a[0] = wa[1];
            rsv_en   = ($urandom_range(0, 99) < 35);
            rsv_addr = ($urandom_range(0, 2) == 0) ? wa[0] : NA'($urandom_range(0, DEP - 1));
            flush    = ($urandom_range(0, 99) < 5);
            #1;
            for (int k = 0; k < NRD; k++) exp_q.push_back(exp_rd_dt(k));
            for (int k = 0; k < NRD; k++) begin
                e = exp_q.pop_front();
                n_tests++;
                if (o_rd_dt[k*ND +: ND] !== e || o_rd_busy[k] !== exp_rd_busy(k)) begin
                    n_fail++;
                    $display("FAIL rand_read c%0d port%0d addr%0d: dt=%h busy=%b want %h/%b",
                             c, k, rd_a[k], o_rd_dt[k*ND +: ND], o_rd_busy[k], e, exp_rd_busy(k));
                end
            end
            tick();
            n_tests++;
            if (o_busy_vec !== ref_pend || o_wr_conflict !== ref_conf) begin
                n_fail++;
                $display("FAIL rand_state c%0d: busy_vec=%h conflict=%b want %h/%b",
                         c, o_busy_vec, o_wr_conflict, ref_pend, ref_conf);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        wr(0, 5'd10, 32'h10101010);
        rsv_en = 1'b1; rsv_addr = 5'd20;
        tick();
        idle();
        wr(1, 5'd4, 32'h44444444);
        rsv_en = 1'b1; rsv_addr = 5'd10;
        rd_a[0] = 5'd10;
        rd_a[1] = 5'd20;
        #2 rst_async_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (o_busy_vec !== '0 || o_wr_conflict !== 1'b0 || o_rd_busy !== '0 ||
            o_rd_dt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_immediate: busy_vec=%h conflict=%b rd_busy=%b rd_dt=%h want all 0",
                     o_busy_vec, o_wr_conflict, o_rd_busy, o_rd_dt);
        end
        @(posedge clk);
        #1;
        idle();
        rst_async_n = 1'b1;
        rd_a[0] = 5'd4;
        rd_a[1] = 5'd10;
        #1;
        n_tests++;
        if (o_rd_dt !== '0 || o_rd_busy !== '0 || o_busy_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_lost_write: rd_dt=%h rd_busy=%b busy_vec=%h want all 0",
                     o_rd_dt, o_rd_busy, o_busy_vec);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle();
        rd_a[0] = '0; rd_a[1] = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
